speaker_arbiter: RTL
====================

Name: speaker_arbiter

Overview:
Shares the single speaker output between up to N_REQ tone sources, such as song players, key beeps and alarms. Each source raises a request and supplies its own square-wave tone. The arbiter grants one owner at a time using round-robin order. It enforces a silent guard gap between owners and a maximum hold time when other sources are waiting. It sits between the tone/song generators and the speaker pin.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_FREQ, 50_000_000, clock frequency in Hz
GAP_MS, 20, silence between two consecutive grants, in ms
MAX_GRANT_MS, 2000, hold time after which a waiting requester may preempt the owner, in ms
CNT_W, 27, width of the shared ms-cycle counter; must hold MAX_GRANT_CYC

Ports:
clk_50MHz  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req  input  N_REQ  level requests, synchronous to clk_50MHz, held while the source wants the speaker
tone_in  input  N_REQ  square-wave tone from each source
grant  output  N_REQ  one-hot grant, all zero when no owner
busy  output  1  high in GRANT and GAP states
preempted  output  1  one-cycle pulse when an owner loses its grant by timeout
speaker  output  1  registered copy of tone_in[owner]; 0 when no owner

Behaviour:
- Interface: one clock, clk_50MHz. Reset rst_n is asynchronous and active-low.
- Derived values: GAP_CYC = CLK_FREQ/1000*GAP_MS and MAX_GRANT_CYC = CLK_FREQ/1000*MAX_GRANT_MS, computed at elaboration as integers.
- Reset values: state=IDLE, grant=0, busy=0, preempted=0, speaker=0, rr_ptr=0, cnt=0. Reset mid-grant silences speaker immediately (asynchronous).
- Arbitration rule: pick the first i with req[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ. On grant, rr_ptr <= winner+1, wrapping to 0 after N_REQ-1.
- IDLE:
  - If req != 0, go to GRANT on the next edge. grant is one-hot to the winner; cnt=0.
  - Latency: req high at edge k gives grant high after edge k+1.
- GRANT:
  - speaker <= tone_in[owner] every cycle, so speaker lags tone_in by one cycle.
  - cnt increments and saturates at MAX_GRANT_CYC.
  - If req[owner]=0: go to GAP, grant=0, cnt=0.
  - Else if cnt==MAX_GRANT_CYC and any other req is high: go to GAP, grant=0, cnt=0, preempted=1 for exactly one cycle.
  - If the owner still requests and nobody else is waiting, it keeps the grant indefinitely.
  - If the owner release and the timeout occur in the same cycle, the release wins: no preempted pulse.
- GAP:
  - grant=0, speaker=0, busy=1, cnt increments.
  - When cnt==GAP_CYC-1: if req != 0, go directly to GRANT using the arbitration rule; else go to IDLE.
  - GAP lasts exactly GAP_CYC cycles.
  - With GAP_MS=0 (GAP_CYC=0), GAP is skipped and GRANT goes straight to the next arbitration.
- A preempted owner still requesting stays eligible. It has lowest priority because rr_ptr already moved past it.
- Requests that rise and fall entirely inside GAP are ignored. Only the level at the decision edge counts.
- The grant and speaker registers update on the same edge, so grant is never high while speaker carries another source.

Optional Feature:
SPK_URGENT_EN
- Defined: req[0] is an urgent source, e.g. an alarm.
  - In GRANT with owner != 0, req[0]=1 forces the next edge to grant 0 directly. No GAP, and preempted pulses.
  - In GAP, req[0]=1 ends the gap immediately and grants 0.
  - In IDLE, req[0] wins regardless of rr_ptr, and rr_ptr is unchanged.
  - The timeout does not apply while owner=0.
- Not defined: requester 0 is a normal round-robin requester and all rules above apply unchanged.

Test Plan:
All scenarios use CLK_FREQ=1000 (1 ms = 1 cycle), GAP_MS=4, MAX_GRANT_MS=20, N_REQ=4.
- Reset: rst_n=0 asynchronously mid-grant -> grant=0, speaker=0, busy=0 with no clock edge. After release, req=4'b0010 -> grant=4'b0010 one edge later.
- Single owner: req[1] held 10 cycles, then dropped -> speaker mirrors tone_in[1] with 1-cycle lag, then exactly 4 silent GAP cycles, then IDLE with busy=0.
- Round-robin: req=4'b1111 held, each owner releases after 5 cycles -> grant order 0,1,2,3,0, each pair separated by a 4-cycle gap.
- Timeout: req[2] held, req[3] rises at cycle 5 -> at grant cycle 20, preempted pulses once. After the 4-cycle gap, grant=4'b1000. req[2] regains the grant only after req[3] drops.
- Timeout with no contender: req[0] alone held 100 cycles -> grant stays 4'b0001 and preempted never pulses.
- SPK_URGENT_EN: owner=1, req[0] rises -> next edge grant=4'b0001, preempted=1, no gap. Without the macro, the same stimulus leaves grant at 4'b0010 until the timeout.

Source files
------------

// File: rtl/speaker_arbiter.sv
// Round-robin owner arbiter for one speaker pin, with a silent guard gap between owners and a hold-time limit.
// Optional build macro SPK_URGENT_EN: requester 0 becomes an urgent source that bypasses round-robin and the gap.
module speaker_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int GAP_MS       = 20,
  parameter int MAX_GRANT_MS = 2000,
  parameter int CNT_W        = 27
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] tone_in,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             preempted,
  output logic             speaker
);

  localparam int GAP_CYC       = CLK_FREQ / 1000 * GAP_MS;
  localparam int MAX_GRANT_CYC = CLK_FREQ / 1000 * MAX_GRANT_MS;
  localparam int IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_GRANT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               speaker_q, speaker_d;
  logic               preempted_q, preempted_d;

  logic               urgent_req;
  logic               timeout_en;
  logic               others_waiting;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   scan_idx [N_REQ];
  logic               leave, decide, take, take_bump;
  logic [IDX_W-1:0]   take_idx;

`ifdef SPK_URGENT_EN
  assign urgent_req = req[0];
  assign timeout_en = (owner_q != '0);
`else
  assign urgent_req = 1'b0;
  assign timeout_en = 1'b1;
`endif

  assign others_waiting = |(req & ~grant_q);

  // scan_idx[k] is the k-th candidate in round-robin order starting at rr_ptr
  for (genvar k = 0; k < N_REQ; k++) begin : g_scan
    assign scan_idx[k] = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
  end

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[scan_idx[k]]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    preempted_d = 1'b0;
    leave       = 1'b0;
    decide      = 1'b0;
    take        = 1'b0;
    take_bump   = 1'b0;
    take_idx    = '0;

    case (state_q)
      S_IDLE: decide = 1'b1;
      S_GRANT: begin
        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
        if (urgent_req && (owner_q != '0)) begin
          take        = 1'b1;
          preempted_d = req[owner_q];
        end else if (!req[owner_q]) begin
          leave = 1'b1;
        end else if (timeout_en && (cnt_q == MAX_CNT) && others_waiting) begin
          leave       = 1'b1;
          preempted_d = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if ((cnt_q == GAP_LAST) || urgent_req) decide = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A zero-length gap hands straight over to the next arbitration
    if (leave) begin
      if (GAP_CYC == 0) begin
        decide = 1'b1;
      end else begin
        state_d = S_GAP;
        grant_d = '0;
        cnt_d   = '0;
      end
    end

    if (decide) begin
      if (urgent_req) begin
        take = 1'b1;
      end else if (win_valid) begin
        take      = 1'b1;
        take_idx  = win_idx;
        take_bump = 1'b1;
      end else begin
        state_d = S_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    end

    if (take) begin
      state_d = S_GRANT;
      owner_d = take_idx;
      grant_d = N_REQ'(1) << take_idx;
      cnt_d   = '0;
      if (take_bump) rr_ptr_d = (take_idx == LAST_IDX) ? '0 : take_idx + 1'b1;
    end

    // Loaded on the same edge as grant so the pin never carries a non-owner
    speaker_d = (state_d == S_GRANT) ? tone_in[owner_d] : 1'b0;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      speaker_q   <= 1'b0;
      preempted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      speaker_q   <= speaker_d;
      preempted_q <= preempted_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign preempted = preempted_q;
  assign speaker   = speaker_q;

endmodule
